// File: rtl/fifo_arbiter.sv
// fifo_arbiter: shares a FIFO's single write port between two producers
// (round-robin), serves one consumer through a read handshake, and can
// drain the FIFO on request. Keeps its own occupancy count so the FIFO is
// never written when full or read when empty.
module fifo_arbiter #(
    parameter int WL    = 10,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req0,
    input  logic          req1,
    input  logic [WL-1:0] data0,
    input  logic [WL-1:0] data1,
    output logic          gnt0,
    output logic          gnt1,
    input  logic          rd_req,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [WL-1:0] rd_data,
    input  logic          flush,
    output logic          busy,
    output logic          flush_done,
    output logic [CW-1:0] count,
    output logic          err_sticky,
    output logic          f_wReq,
    output logic          f_rReq,
    output logic [WL-1:0] f_din,
    input  logic [WL-1:0] f_dout,
    input  logic          f_full,
    input  logic          f_empty,
    input  logic          f_error
);

    localparam logic [1:0] NORMAL     = 2'd0;
    localparam logic [1:0] FLUSH      = 2'd1;
    localparam logic [1:0] FLUSH_WAIT = 2'd2;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic          last_reg, last_next;
    logic          wait_reg, wait_next;
    logic          f_wreq_reg, f_rreq_reg;
    logic [WL-1:0] f_din_reg;
    logic          rd_pend_reg, rd_valid_reg;
    logic          flush_done_reg, err_reg;

    logic          in_normal, can_wr, wr_acc, flush_rd, any_rd;
    logic [1:0]    req_v, gnt_v;
    logic [WL-1:0] wr_data;

    // FIFO full/empty flags are monitoring-only; the local count is authoritative.
    logic unused_flags;
    assign unused_flags = f_full ^ f_empty;

    // Grants and read acks are suppressed while in reset so nothing is accepted then.
    assign in_normal = (state_reg == NORMAL) && !RST;
    assign can_wr    = in_normal && (count_reg < DEPTH_C);
    assign req_v     = {req1, req0};

    // A requester wins if it is alone, or if both request and it was not the last winner.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign gnt_v[gi] = can_wr && req_v[gi] &&
                               (!req_v[1-gi] || (last_reg != 1'(gi)));
        end
    endgenerate

    assign gnt0     = gnt_v[0];
    assign gnt1     = gnt_v[1];
    assign wr_acc   = |gnt_v;
    assign wr_data  = gnt_v[1] ? data1 : (gnt_v[0] ? data0 : '0);
    assign rd_ack   = in_normal && rd_req && (count_reg != '0);
    assign flush_rd = (state_reg == FLUSH) && (count_reg != '0);
    assign any_rd   = rd_ack || flush_rd;

    assign busy       = (state_reg != NORMAL);
    assign count      = count_reg;
    assign f_wReq     = f_wreq_reg;
    assign f_rReq     = f_rreq_reg;
    assign f_din      = f_din_reg;
    assign rd_valid   = rd_valid_reg;
    // f_dout is refreshed on the edge that registers rd_valid, so pass it through while valid.
    assign rd_data    = rd_valid_reg ? f_dout : '0;
    assign flush_done = flush_done_reg;
    assign err_sticky = err_reg;

    // Next-state, occupancy and round-robin pointer updates.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        last_next  = last_reg;
        wait_next  = 1'b0;

        if (wr_acc && !any_rd)
            count_next = count_reg + CW'(1);
        else if (any_rd && !wr_acc)
            count_next = count_reg - CW'(1);

        if (gnt_v[1])
            last_next = 1'b1;
        else if (gnt_v[0])
            last_next = 1'b0;

        case (state_reg)
            NORMAL: begin
                if (flush)
                    state_next = FLUSH;
            end
            FLUSH: begin
                // Leave once the final drain read is issued (or nothing was stored).
                if (count_reg <= CW'(1))
                    state_next = FLUSH_WAIT;
            end
            FLUSH_WAIT: begin
                wait_next = !wait_reg;
                if (wait_reg)
                    state_next = NORMAL;
            end
            default: state_next = NORMAL;
        endcase
    end

    // Registered state, FIFO request outputs and consumer read pipeline.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= NORMAL;
            count_reg      <= '0;
            last_reg       <= 1'b1;
            wait_reg       <= 1'b0;
            f_wreq_reg     <= 1'b0;
            f_rreq_reg     <= 1'b0;
            f_din_reg      <= '0;
            rd_pend_reg    <= 1'b0;
            rd_valid_reg   <= 1'b0;
            flush_done_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            last_reg       <= last_next;
            wait_reg       <= wait_next;
            f_wreq_reg     <= wr_acc;
            f_rreq_reg     <= any_rd;
            f_din_reg      <= wr_data;
            // Only consumer reads are tagged; drained words never raise rd_valid.
            rd_pend_reg    <= rd_ack;
            rd_valid_reg   <= rd_pend_reg;
            flush_done_reg <= (state_reg == FLUSH_WAIT) && !wait_reg;
            err_reg        <= err_reg || f_error;
        end
    end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Testbench for fifo_arbiter with a behavioural 4-deep FIFO and a data scoreboard.
module tb_fifo_arbiter;

    localparam int WL = 10;
    localparam int DEPTH = 4;
    localparam int CW = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, rd_req = 1'b0, flush = 1'b0;
    logic [WL-1:0] data0 = '0, data1 = '0;
    logic          gnt0, gnt1, rd_ack, rd_valid, busy, flush_done, err_sticky;
    logic          f_wReq, f_rReq, f_full, f_empty, f_error;
    logic [WL-1:0] rd_data, f_din;
    logic [WL-1:0] f_dout;
    logic [CW-1:0] count;
    logic          err_force = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [WL-1:0] exp_q[$];
    logic [WL-1:0] exp_word;

    fifo_arbiter #(.WL(WL), .DEPTH(DEPTH), .CW(CW)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .flush(flush), .busy(busy), .flush_done(flush_done),
        .count(count), .err_sticky(err_sticky),
        .f_wReq(f_wReq), .f_rReq(f_rReq), .f_din(f_din), .f_dout(f_dout),
        .f_full(f_full), .f_empty(f_empty), .f_error(f_error)
    );

    always #5 CLK = ~CLK;

    // Behavioural FIFO: flags misuse through its error output.
    logic [WL-1:0] mem [0:DEPTH-1];
    logic [1:0]    wp, rp;
    int            occ;
    logic          model_err;
    logic          do_w, do_r;
    assign do_w    = f_wReq && (occ < DEPTH);
    assign do_r    = f_rReq && (occ > 0);
    assign f_full  = (occ == DEPTH);
    assign f_empty = (occ == 0);
    assign f_error = model_err || err_force;

    always @(posedge CLK) begin
        if (RST) begin
            wp <= '0; rp <= '0; occ <= 0; f_dout <= '0; model_err <= 1'b0;
        end else begin
            model_err <= (f_wReq && !do_w) || (f_rReq && !do_r);
            if (do_w) begin mem[wp] <= f_din; wp <= wp + 2'd1; end
            if (do_r) begin f_dout <= mem[rp]; rp <= rp + 2'd1; end
            occ <= occ + int'(do_w) - int'(do_r);
        end
    end

    // Scoreboard: granted data is queued; every rd_valid must return the oldest entry.
    always @(negedge CLK) begin
        if (!RST) begin
            if (gnt0) exp_q.push_back(data0);
            if (gnt1) exp_q.push_back(data1);
            if (rd_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_data: rd_valid with nothing expected, got %h", rd_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (rd_data !== exp_word) begin
                        errors++;
                        $display("FAIL rd_data: got %h expected %h", rd_data, exp_word);
                    end else
                        $display("read  data=%h ok", rd_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_n(input logic [WL-1:0] base, input int n);
        req0 = 1'b1;
        for (int i = 0; i < n; i++) begin
            data0 = base + WL'(i);
            tick();
        end
        req0 = 1'b0;
    endtask

    task automatic drain(input int n);
        rd_req = 1'b1;
        repeat (n) tick();
        rd_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({gnt0, gnt1, rd_ack, rd_valid, busy, flush_done, err_sticky, f_wReq, f_rReq} !== 9'b0 ||
            count !== 3'd0 || f_din !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset: flags=%b count=%0d f_din=%h rd_data=%h expected all 0",
                     {gnt0, gnt1, rd_ack, rd_valid, busy, flush_done, err_sticky, f_wReq, f_rReq},
                     count, f_din, rd_data);
        end else
            $display("reset state ok");
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        req0 = 1'b1; req1 = 1'b1; data0 = 10'h001; data1 = 10'h002;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i >= 4) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge CLK);
            checks++;
            if ({gnt1, gnt0} !== exp_g) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", i, {gnt1, gnt0}, exp_g);
            end else
                $display("rr cycle %0d grants=%b", i, {gnt1, gnt0});
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge CLK);
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL rr_count: got %0d expected 4", count);
        end
        tick();
        drain(4);
    endtask

    task automatic test_fill_drain();
        logic exp_ack, exp_vld;
        write_n(10'h00A, 4);
        rd_req = 1'b1;
        for (int k = 0; k < 7; k++) begin
            exp_ack = (k < 4);
            exp_vld = (k >= 2) && (k < 6);
            @(negedge CLK);
            checks++;
            if (rd_ack !== exp_ack || rd_valid !== exp_vld) begin
                errors++;
                $display("FAIL drain_hs[%0d]: ack=%b valid=%b expected ack=%b valid=%b",
                         k, rd_ack, rd_valid, exp_ack, exp_vld);
            end
            tick();
        end
        rd_req = 1'b0;
        tick();
        @(negedge CLK);
        checks++;
        if (count !== 3'd0 || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: count=%0d err=%b expected 0 0", count, err_sticky);
        end else
            $display("fill/drain done count=0");
        tick();
    endtask

    task automatic test_simultaneous();
        write_n(10'h010, 4);
        req0 = 1'b1; data0 = 10'h0EE; rd_req = 1'b1;
        @(negedge CLK);
        checks++;
        if (gnt0 !== 1'b0 || rd_ack !== 1'b1) begin
            errors++;
            $display("FAIL sim_full: gnt0=%b rd_ack=%b expected 0 1", gnt0, rd_ack);
        end
        tick();
        req0 = 1'b0; rd_req = 1'b0;
        @(negedge CLK);
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL sim_full_count: got %0d expected 3", count);
        end
        tick();
        drain(3);
        req0 = 1'b1; data0 = 10'h020; rd_req = 1'b1;
        @(negedge CLK);
        checks++;
        if (gnt0 !== 1'b1 || rd_ack !== 1'b0) begin
            errors++;
            $display("FAIL sim_empty: gnt0=%b rd_ack=%b expected 1 0", gnt0, rd_ack);
        end
        tick();
        rd_req = 1'b0; data0 = 10'h021;
        @(negedge CLK);
        checks++;
        if (count !== 3'd1) begin
            errors++;
            $display("FAIL sim_empty_count: got %0d expected 1", count);
        end
        tick();
        data0 = 10'h022; rd_req = 1'b1;
        @(negedge CLK);
        checks++;
        if (gnt0 !== 1'b1 || rd_ack !== 1'b1) begin
            errors++;
            $display("FAIL sim_mid: gnt0=%b rd_ack=%b expected 1 1", gnt0, rd_ack);
        end
        tick();
        req0 = 1'b0; rd_req = 1'b0;
        @(negedge CLK);
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL sim_mid_count: got %0d expected 2", count);
        end else
            $display("simultaneous at count=2 kept count=2");
        tick();
        drain(2);
    endtask

    task automatic test_flush(input int fill, input int done_k);
        int rq;
        logic exp_done, exp_busy;
        rq = 0;
        if (fill > 0) write_n(10'h030, fill);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 1; k <= done_k + 3; k++) begin
            exp_done = (k == done_k);
            exp_busy = (k <= done_k);
            @(negedge CLK);
            if (f_rReq) rq++;
            checks++;
            if (flush_done !== exp_done || busy !== exp_busy || rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush%0d[%0d]: done=%b busy=%b valid=%b expected %b %b 0",
                         fill, k, flush_done, busy, rd_valid, exp_done, exp_busy);
            end
            tick();
        end
        @(negedge CLK);
        checks++;
        if (rq != fill || count !== 3'd0) begin
            errors++;
            $display("FAIL flush%0d_reads: f_rReq pulses=%0d count=%0d expected %0d 0",
                     fill, rq, count, fill);
        end else
            $display("flush of %0d words done", fill);
        tick();
        exp_q.delete();
    endtask

    task automatic test_flush_readback();
        req1 = 1'b1; data1 = 10'h155;
        @(negedge CLK);
        checks++;
        if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL post_flush_gnt1: got %b expected 1", gnt1);
        end
        tick();
        req1 = 1'b0;
        drain(1);
    endtask

    task automatic test_reset_mid_flush();
        write_n(10'h040, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0; RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b1 || count !== 3'd2) begin
            errors++;
            $display("FAIL midflush_pre: busy=%b count=%0d expected 1 2", busy, count);
        end
        tick();
        RST = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        checks++;
        if ({gnt0, gnt1, rd_ack, rd_valid, busy, flush_done, err_sticky, f_wReq, f_rReq} !== 9'b0 ||
            count !== 3'd0 || f_din !== '0) begin
            errors++;
            $display("FAIL midflush_reset: flags=%b count=%0d f_din=%h expected all 0",
                     {gnt0, gnt1, rd_ack, rd_valid, busy, flush_done, err_sticky, f_wReq, f_rReq},
                     count, f_din);
        end else
            $display("reset during flush ok");
        tick();
        req1 = 1'b1; data1 = 10'h0AB;
        @(negedge CLK);
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL midflush_gnt1: gnt1=%b gnt0=%b expected 1 0", gnt1, gnt0);
        end
        tick();
        req1 = 1'b0;
        drain(1);
    endtask

    task automatic test_error();
        @(negedge CLK);
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL err_before: got %b expected 0", err_sticky);
        end
        tick();
        err_force = 1'b1;
        tick();
        err_force = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            checks++;
            if (err_sticky !== 1'b1) begin
                errors++;
                $display("FAIL err_sticky: got %b expected 1", err_sticky);
            end
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: got %b expected 0", err_sticky);
        end else
            $display("error monitor ok");
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fill_drain();
        test_simultaneous();
        test_flush(3, 5);
        test_flush_readback();
        test_flush(0, 3);
        test_reset_mid_flush();
        test_error();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
